// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
//   Shares one single-port synchronous RAM between the instruction-fetch port
//   (if_*) and the load/store port (dm_*). At most one access is granted per
//   cycle. The data port has priority, but a fetch that has been refused
//   STARVE_MAX cycles in a row is forced through. Read data comes straight
//   from the RAM one cycle after the grant and is steered to its owner with a
//   valid strobe.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   if_req/if_addr            fetch request and byte address
//   if_gnt                    fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata        fetch response, one cycle after if_gnt
//   dm_req/dm_we/dm_addr      load/store request, direction, byte address
//   dm_wmask/dm_wdata         store byte enables and data
//   dm_gnt                    load/store accepted this cycle (combinational)
//   dm_rvalid/dm_rdata        load response, one cycle after a load grant
//   ram_en/ram_we/ram_addr    RAM command (word address)
//   ram_wmask/ram_wdata       RAM byte enables and write data
//   ram_rdata                 RAM read data, valid the cycle after a read
//   dbg_starve_cnt            current consecutive-denied fetch count
//   dbg_rd_owner              read-tracking state (0 none, 1 fetch, 2 data)
//
// Handshake: a requester raises *_req with its command and holds every
// command input stable until it sees *_gnt high in the same cycle; the
// transfer happens on the rising edge that ends that cycle. There is no
// back-pressure on responses: *_rvalid is a one-cycle strobe.

module mem_port_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic                                 if_req,
    input  logic [31:0]                          if_addr,
    output logic                                 if_gnt,
    output logic                                 if_rvalid,
    output logic [DATA_W-1:0]                    if_rdata,

    input  logic                                 dm_req,
    input  logic                                 dm_we,
    input  logic [31:0]                          dm_addr,
    input  logic [DATA_W/8-1:0]                  dm_wmask,
    input  logic [DATA_W-1:0]                    dm_wdata,
    output logic                                 dm_gnt,
    output logic                                 dm_rvalid,
    output logic [DATA_W-1:0]                    dm_rdata,

    output logic                                 ram_en,
    output logic                                 ram_we,
    output logic [ADDR_W-1:0]                    ram_addr,
    output logic [DATA_W/8-1:0]                  ram_wmask,
    output logic [DATA_W-1:0]                    ram_wdata,
    input  logic [DATA_W-1:0]                    ram_rdata,

    output logic [$clog2(STARVE_MAX+1)-1:0]      dbg_starve_cnt,
    output logic [1:0]                           dbg_rd_owner
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int MW = DATA_W / 8;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } rd_owner_e;

    rd_owner_e       rd_owner_q, rd_owner_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            force_if;

    // Word index only; byte offset and the bits above the RAM range are
    // dropped, so upper addresses alias onto the RAM.
    logic [ADDR_W-1:0] if_word;
    logic [ADDR_W-1:0] dm_word;
    logic              unused_addr_bits;

    assign if_word = if_addr[ADDR_W+1:2];
    assign dm_word = dm_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                dm_addr[31:ADDR_W+2], dm_addr[1:0]};

    // Grant: data port wins unless fetch has waited its full budget.
    always_comb begin
        force_if = if_req && (starve_q == STARVE_TOP);
        dm_gnt   = dm_req && !force_if;
        if_gnt   = if_req && !dm_gnt;
    end

    // RAM command from whichever port was granted.
    always_comb begin
        ram_en    = if_gnt || dm_gnt;
        ram_we    = dm_gnt && dm_we;
        ram_addr  = dm_gnt ? dm_word : if_word;
        ram_wmask = ram_we ? dm_wmask : {MW{1'b0}};
        ram_wdata = dm_wdata;
    end

    // Starvation counter and read-owner next state.
    always_comb begin
        starve_d   = starve_q;
        rd_owner_d = OWN_NONE;

        if (if_gnt || !if_req) begin
            starve_d = '0;
        end else if (starve_q != STARVE_TOP) begin
            starve_d = starve_q + 1'b1;
        end

        if (if_gnt) begin
            rd_owner_d = OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            rd_owner_d = OWN_DM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q   <= '0;
            rd_owner_q <= OWN_NONE;
        end else begin
            starve_q   <= starve_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Responses come straight off the RAM output; the owner register is
    // what turns the shared read bus into per-port strobes.
    always_comb begin
        if_rvalid = (rd_owner_q == OWN_IF);
        dm_rvalid = (rd_owner_q == OWN_DM);
        if_rdata  = ram_rdata;
        dm_rdata  = ram_rdata;
    end

    assign dbg_starve_cnt = starve_q;
    assign dbg_rd_owner   = rd_owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 3;
  localparam int DEPTH      = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [3:0]  dm_wmask = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        ram_en, ram_we;
  logic [5:0]  ram_addr;
  logic [3:0]  ram_wmask;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [1:0]  dbg_starve_cnt;
  logic [1:0]  dbg_rd_owner;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wmask(dm_wmask), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wmask(ram_wmask), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .dbg_starve_cnt(dbg_starve_cnt), .dbg_rd_owner(dbg_rd_owner)
  );

  // ---------------- RAM attached to the DUT ----------------
  logic [31:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram_mem[ram_addr];
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // The model tracks what memory must hold, how many cycles fetch has been
  // refused in a row, and which responses are owed next cycle.
  logic [31:0] exp_q[$];
  int          own_q[$];          // 1 = fetch response, 2 = data response
  logic [31:0] model_mem [DEPTH];
  int          denied = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i]   = 32'hC0DE_0000 | i;
      model_mem[i] = 32'hC0DE_0000 | i;
    end
    ram_mem[4]   = 32'h1122_3344;
    model_mem[4] = 32'h1122_3344;
  end

  always @(negedge clk) begin
    int          owner, winner, w;
    logic [31:0] d;
    logic        e_if_rv, e_dm_rv;
    if (rst) begin
      exp_q.delete();
      own_q.delete();
      denied = 0;
      chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
      chk("rst_starve", {30'd0, dbg_starve_cnt}, 32'd0);
    end else begin
      e_if_rv = 1'b0;
      e_dm_rv = 1'b0;
      d = '0;
      if (own_q.size() > 0) begin
        owner = own_q.pop_front();
        d = exp_q.pop_front();
        if (owner == 1) e_if_rv = 1'b1; else e_dm_rv = 1'b1;
      end
      chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, e_if_rv});
      chk("dm_rvalid", {31'd0, dm_rvalid}, {31'd0, e_dm_rv});
      if (e_if_rv) chk("if_rdata", if_rdata, d);
      if (e_dm_rv) chk("dm_rdata", dm_rdata, d);
      chk("starve_cnt", {30'd0, dbg_starve_cnt}, denied);

      // 0 none, 1 fetch, 2 data
      if (dm_req && !(if_req && denied >= STARVE_MAX)) winner = 2;
      else if (if_req) winner = 1;
      else winner = 0;

      chk("if_gnt", {31'd0, if_gnt}, {31'd0, winner == 1});
      chk("dm_gnt", {31'd0, dm_gnt}, {31'd0, winner == 2});
      chk("ram_en", {31'd0, ram_en}, {31'd0, winner != 0});
      chk("ram_we", {31'd0, ram_we}, {31'd0, winner == 2 && dm_we});
      chk("ram_wmask", {28'd0, ram_wmask}, (winner == 2 && dm_we) ? {28'd0, dm_wmask} : 32'd0);

      if (winner == 1) begin
        w = int'(if_addr % 256) / 4;
        chk("ram_addr_if", {26'd0, ram_addr}, w);
        own_q.push_back(1);
        exp_q.push_back(model_mem[w]);
      end else if (winner == 2) begin
        w = int'(dm_addr % 256) / 4;
        chk("ram_addr_dm", {26'd0, ram_addr}, w);
        if (dm_we) begin
          chk("ram_wdata", ram_wdata, dm_wdata);
          for (int b = 0; b < 4; b++)
            if (dm_wmask[b]) model_mem[w][8*b +: 8] = dm_wdata[8*b +: 8];
        end else begin
          own_q.push_back(2);
          exp_q.push_back(model_mem[w]);
        end
      end

      if (if_req && winner != 1) denied = (denied < STARVE_MAX) ? denied + 1 : STARVE_MAX;
      else denied = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(input logic req, input logic [31:0] addr);
    if_req  = req;
    if_addr = addr;
  endtask

  task automatic drive_dm(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] wdata);
    dm_req   = req;
    dm_we    = we;
    dm_addr  = addr;
    dm_wmask = mask;
    dm_wdata = wdata;
  endtask

  // ---------------- directed stimulus with hand expectations ----------------
  logic [7:0] fetch_pattern;

  initial begin
    drive_if(1'b0, 32'h0);
    drive_dm(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: fetch-only stream
    for (int i = 0; i < 4; i++) begin
      drive_if(i < 3, 32'(i * 4));
      @(negedge clk);
      if (i < 3) chk("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
      if (i > 0) begin
        chk("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("t1_if_rdata", if_rdata, 32'hC0DE_0000 + 32'(i - 1));
      end
      chk("t1_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
      step();
    end
    drive_if(1'b0, 32'h0);

    // 2: partial store, then load back
    drive_dm(1'b1, 1'b1, 32'h10, 4'b0011, 32'hAABB_CCDD);
    @(negedge clk);
    chk("t2_ram_we", {31'd0, ram_we}, 32'd1);
    chk("t2_ram_addr", {26'd0, ram_addr}, 32'd4);
    step();
    drive_dm(1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);
    @(negedge clk);
    chk("t2_st_no_rvalid", {31'd0, dm_rvalid}, 32'd0);
    step();
    drive_dm(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t2_dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
    chk("t2_dm_rdata", dm_rdata, 32'h1122_CCDD);
    step();

    // 3: both ports loading continuously
    drive_if(1'b1, 32'hC);
    drive_dm(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fetch_pattern[i] = if_gnt;
      step();
    end
    chk("t3_grant_pattern", {24'd0, fetch_pattern}, 32'h88);
    drive_if(1'b0, 32'h0);
    drive_dm(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    step();

    // 4: upper address bits alias
    drive_dm(1'b1, 1'b0, 32'h104, 4'h0, 32'h0);
    @(negedge clk);
    chk("t4_ram_addr", {26'd0, ram_addr}, 32'd1);
    step();
    drive_dm(1'b1, 1'b0, 32'h004, 4'h0, 32'h0);
    @(negedge clk);
    chk("t4_alias_rdata", dm_rdata, 32'hC0DE_0001);
    step();
    drive_dm(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t4_direct_rdata", dm_rdata, 32'hC0DE_0001);
    step();

    // 5: reset lands while a fetch response is in flight
    drive_if(1'b1, 32'h8);
    @(negedge clk);
    chk("t5_if_gnt", {31'd0, if_gnt}, 32'd1);
    step();
    rst = 1'b1;
    drive_if(1'b0, 32'h0);
    @(negedge clk);
    chk("t5_dropped", {31'd0, if_rvalid}, 32'd0);
    step();
    rst = 1'b0;
    drive_if(1'b1, 32'h0);
    @(negedge clk);
    chk("t5_if_rvalid_after", {31'd0, if_rvalid}, 32'd0);
    chk("t5_starve_zero", {30'd0, dbg_starve_cnt}, 32'd0);
    chk("t5_first_gnt", {31'd0, if_gnt}, 32'd1);
    step();
    drive_if(1'b0, 32'h0);
    @(negedge clk);
    chk("t5_if_rdata", if_rdata, 32'hC0DE_0000);
    step();

    // 6: store + load back-to-back while fetch waits
    drive_if(1'b1, 32'h10);
    drive_dm(1'b1, 1'b1, 32'h14, 4'b1111, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t6_if_wait1", {31'd0, if_gnt}, 32'd0);
    step();
    drive_dm(1'b1, 1'b0, 32'h14, 4'h0, 32'h0);
    @(negedge clk);
    chk("t6_if_wait2", {31'd0, if_gnt}, 32'd0);
    chk("t6_no_store_rv", {31'd0, dm_rvalid}, 32'd0);
    step();
    drive_dm(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t6_dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
    chk("t6_raw_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("t6_if_gnt", {31'd0, if_gnt}, 32'd1);
    step();
    drive_if(1'b0, 32'h0);
    @(negedge clk);
    chk("t6_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t6_dm_quiet", {31'd0, dm_rvalid}, 32'd0);
    chk("t6_if_rdata", if_rdata, 32'h1122_CCDD);
    step();
    step();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
